// File: rtl/rect_cf_share_compress.sv
// rect_cf_share_compress
// Register stage (glitch barrier) for the raw component-function term bits of
// the RECTANGLE 3-share masked S-box, followed by a registered XOR compression
// into 3 output shares per component function. Valid/ready handshaking on both
// sides, plus an S-box batch counter that flags the last S-box of a state.
//
// Optional build macro: RECT_CF_REFRESH_EN
//   Adds a 2*NCF-bit rnd input, captured with the terms, that re-masks the
//   three shares of each component function without changing their XOR.

module rect_cf_share_compress #(
    parameter int NCF   = 4,
    parameter int NSBOX = 16,
    parameter int CW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [18*NCF-1:0]   in_terms,
`ifdef RECT_CF_REFRESH_EN
    input  logic [2*NCF-1:0]    rnd,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*NCF-1:0]    out_shares,
    output logic                out_last,
    output logic [CW-1:0]       batch_cnt
);

    logic                s1_valid;
    logic [18*NCF-1:0]   s1_terms;
    logic                s2_load;
    logic                in_accept;
    logic                out_fire;
    logic [3*NCF-1:0]    shares_next;

`ifdef RECT_CF_REFRESH_EN
    logic [2*NCF-1:0]    s1_rnd;
`endif

    // Handshake: s2 takes s1 when it is empty or being drained this cycle.
    always_comb begin
        s2_load   = s1_valid && (!out_valid || out_ready);
        in_ready  = !s1_valid || s2_load;
        in_accept = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_last  = out_valid && (batch_cnt == CW'(NSBOX - 1));
    end

    // Stage 1: raw terms captured untouched so no glitches reach the XOR tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
`ifdef RECT_CF_REFRESH_EN
            s1_rnd   <= '0;
`endif
        end else begin
            if (in_accept) begin
                s1_valid <= 1'b1;
                s1_terms <= in_terms;
`ifdef RECT_CF_REFRESH_EN
                s1_rnd   <= rnd;
`endif
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Share j of each CF only combines terms built on b-share j+1:
    // terms {3j..3j+2} and {9+3j..11+3j}.
    always_comb begin
        shares_next = '0;
        for (int f = 0; f < NCF; f++) begin
            for (int j = 0; j < 3; j++) begin
                shares_next[3*f+j] = ^{s1_terms[18*f+3*j +: 3],
                                       s1_terms[18*f+9+3*j +: 3]};
            end
`ifdef RECT_CF_REFRESH_EN
            shares_next[3*f+0] = shares_next[3*f+0] ^ s1_rnd[2*f];
            shares_next[3*f+1] = shares_next[3*f+1] ^ s1_rnd[2*f+1];
            shares_next[3*f+2] = shares_next[3*f+2] ^ s1_rnd[2*f] ^ s1_rnd[2*f+1];
`endif
        end
    end

    // Stage 2: compressed shares; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_shares <= '0;
        end else begin
            if (s2_load) begin
                out_valid  <= 1'b1;
                out_shares <= shares_next;
            end else if (out_fire) begin
                out_valid  <= 1'b0;
            end
        end
    end

    // Batch counter: counts delivered S-boxes, wraps on the last of the batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            batch_cnt <= '0;
        end else if (out_fire) begin
            if (out_last) begin
                batch_cnt <= '0;
            end else begin
                batch_cnt <= batch_cnt + CW'(1);
            end
        end
    end

endmodule
